// File: rtl/rb_window_ctrl.sv
`default_nettype none
// ============================================================================
// rb_window_ctrl : sequencer for K-1 circular row buffers and the steer stage
// Revision       : 1.0
// ============================================================================
module rb_window_ctrl #(
  parameter  int KERNEL_SIZE = 9,
  parameter  int IMG_WIDTH   = 64,
  parameter  int IMG_HEIGHT  = 64,
  localparam int CW          = $clog2(IMG_WIDTH),
  localparam int RW          = $clog2(IMG_HEIGHT),
  localparam int SW          = $clog2(KERNEL_SIZE - 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          rb_en,
  output logic [CW-1:0] rb_addr,
  output logic [SW-1:0] rb_wr_sel,
  output logic [SW-1:0] steer_sel,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done
);

  localparam int            RB_COUNT  = KERNEL_SIZE - 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] FILL_LAST = RW'(KERNEL_SIZE - 2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(RB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] wr_sel_q, wr_sel_d;
  logic          drain_q, drain_d;
  logic [SW-1:0] steer_sel_q, steer_sel_d;
  logic          pv_q, pv_d;
  logic [CW-1:0] pcol_q, pcol_d;
  logic [RW-1:0] prow_q, prow_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          accept;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wr_sel_d    = wr_sel_q;
    drain_d     = drain_q;
    steer_sel_d = steer_sel_q;
    pcol_d      = pcol_q;
    prow_d      = prow_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    in_ready    = (state_q == FILL) || (state_q == ACTIVE);
    accept      = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          col_d    = '0;
          row_d    = '0;
          wr_sel_d = '0;
          drain_d  = 1'b0;
        end
      end
      FILL, ACTIVE: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d    = '0;
            row_d    = row_q + RW'(1);
            wr_sel_d = (wr_sel_q == SEL_LAST) ? '0 : wr_sel_q + SW'(1);
            if (state_q == FILL && row_q == FILL_LAST) begin
              state_d = ACTIVE;
            end else if (state_q == ACTIVE && row_q == ROW_LAST) begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        // Two drain cycles let the last accepted column reach win_valid.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The buffer being overwritten holds the oldest row, so it leads the rotation.
    if (accept) begin
      steer_sel_d = wr_sel_q;
      pcol_d      = col_q;
      prow_d      = row_q;
    end
    pv_d        = accept && (state_q == ACTIVE);
    win_valid_d = pv_q;
    if (pv_q) begin
      win_col_d = pcol_q;
      win_row_d = prow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      wr_sel_q    <= '0;
      drain_q     <= 1'b0;
      steer_sel_q <= '0;
      pv_q        <= 1'b0;
      pcol_q      <= '0;
      prow_q      <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_sel_q    <= wr_sel_d;
      drain_q     <= drain_d;
      steer_sel_q <= steer_sel_d;
      pv_q        <= pv_d;
      pcol_q      <= pcol_d;
      prow_q      <= prow_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign rb_en      = accept;
  assign rb_addr    = col_q;
  assign rb_wr_sel  = wr_sel_q;
  assign steer_sel  = steer_sel_q;
  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE) && drain_q;

endmodule
`default_nettype wire

// File: tb/tb_rb_window_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rb_window_ctrl : directed self-checking bench for rb_window_ctrl
// Revision          : 1.0
// ============================================================================
module tb_rb_window_ctrl;

  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 6;
  localparam int NV = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       rb_en;
  logic [1:0] rb_addr;
  logic [0:0] rb_wr_sel;
  logic [0:0] steer_sel;
  logic       win_valid;
  logic [1:0] win_col;
  logic [2:0] win_row;
  logic       busy;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic start;
    logic in_valid;
    logic in_ready;
    logic rb_en;
    int   rb_addr;
    int   wr_sel;
    int   steer;
    logic win_valid;
    int   win_col;
    int   win_row;
    logic busy;
    logic frame_done;
  } vec_t;

  vec_t vecs[NV];

  rb_window_ctrl #(
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rb_en     (rb_en),
    .rb_addr   (rb_addr),
    .rb_wr_sel (rb_wr_sel),
    .steer_sel (steer_sel),
    .win_valid (win_valid),
    .win_col   (win_col),
    .win_row   (win_row),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"},   in_ready,   0);
    check({tag, " rb_en"},      rb_en,      0);
    check({tag, " rb_addr"},    rb_addr,    0);
    check({tag, " rb_wr_sel"},  rb_wr_sel,  0);
    check({tag, " steer_sel"},  steer_sel,  0);
    check({tag, " win_valid"},  win_valid,  0);
    check({tag, " win_col"},    win_col,    0);
    check({tag, " win_row"},    win_row,    0);
    check({tag, " busy"},       busy,       0);
    check({tag, " frame_done"}, frame_done, 0);
  endtask

  // Expected per-cycle outputs from pixel-index arithmetic: pixel p sits at
  // column p%W, row p/W, and is written into buffer row%(K-1).
  task automatic build_table();
    int p       = 0;
    int steer   = 0;
    bit started = 1'b0;
    int t_last  = 1000;
    bit acc_h[NV];
    int pix_h[NV];
    for (int c = 0; c < NV; c++) begin
      vec_t v;
      bit   rdy;
      v.start       = (c == 0) || (c == 3);
      v.in_valid    = !(c == 11 || c == 13);
      rdy           = started && (p < H * W);
      v.in_ready    = rdy;
      v.rb_en       = v.in_valid && rdy;
      v.rb_addr     = p % W;
      v.wr_sel      = (p / W) % (K - 1);
      v.steer       = steer;
      v.win_valid   = (c >= 2) && acc_h[(c >= 2) ? c - 2 : 0] &&
                      (pix_h[(c >= 2) ? c - 2 : 0] / W >= K - 1);
      v.win_col     = v.win_valid ? pix_h[c - 2] % W : 0;
      v.win_row     = v.win_valid ? pix_h[c - 2] / W : 0;
      v.busy        = started && (c <= t_last + 2);
      v.frame_done  = (c == t_last + 2);
      acc_h[c]      = v.rb_en;
      pix_h[c]      = p;
      if (v.rb_en) begin
        steer = (p / W) % (K - 1);
        if (p == H * W - 1) t_last = c;
        p++;
      end
      if (c == 0) started = 1'b1;
      vecs[c] = v;
    end
  endtask

  initial begin
    int wins;
    int dones;
    int cyc;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Full frame with a start in IDLE, a stray start in FILL and an in_valid
    // toggle pattern in ACTIVE.
    wins = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start    = vecs[i].start;
      in_valid = vecs[i].in_valid;
      #1;
      check($sformatf("v%0d in_ready", i),   in_ready,   vecs[i].in_ready);
      check($sformatf("v%0d rb_en", i),      rb_en,      vecs[i].rb_en);
      check($sformatf("v%0d rb_addr", i),    rb_addr,    vecs[i].rb_addr);
      check($sformatf("v%0d rb_wr_sel", i),  rb_wr_sel,  vecs[i].wr_sel);
      check($sformatf("v%0d steer_sel", i),  steer_sel,  vecs[i].steer);
      check($sformatf("v%0d win_valid", i),  win_valid,  vecs[i].win_valid);
      check($sformatf("v%0d busy", i),       busy,       vecs[i].busy);
      check($sformatf("v%0d frame_done", i), frame_done, vecs[i].frame_done);
      if (vecs[i].win_valid) begin
        check($sformatf("v%0d win_col", i), win_col, vecs[i].win_col);
        check($sformatf("v%0d win_row", i), win_row, vecs[i].win_row);
      end
      if (win_valid) wins++;
    end
    check("table win_valid count", wins, (H - K + 1) * W);

    // Reset in the middle of ACTIVE abandons the frame.
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("pre-reset busy", busy, 1);
    check("pre-reset win_valid", win_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");

    // A fresh frame after the abort runs to completion.
    start = 1'b1;
    wins  = 0;
    dones = 0;
    cyc   = 0;
    while (dones == 0 && cyc < 80) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (win_valid) wins++;
      if (frame_done) dones++;
      cyc++;
    end
    check("post-reset frame_done seen", dones, 1);
    check("post-reset win_valid count", wins, (H - K + 1) * W);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("post-frame busy", busy, 0);
    check("post-frame frame_done", frame_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rb_window_ctrl.md
Name: rb_window_ctrl

Overview:
- Sequencing controller for the row-buffer window datapath.
- Accepts a raster pixel stream for one frame and generates the shared column address, the write enables and the write-buffer index for the K-1 circular row buffers.
- Drives the rotation select of the steer stage so that its output is ordered oldest-row-first, and flags when a full KxK column window is valid at the steer output.
- Sits between the pixel source and the row-buffer/steer datapath.

Parameters:
KERNEL_SIZE, 9, KxK kernel size; odd and >=3; RB_COUNT = KERNEL_SIZE-1 row buffers
IMG_WIDTH, 64, pixels per row; >=2
IMG_HEIGHT, 64, rows per frame; >=KERNEL_SIZE
(derived) CW = $clog2(IMG_WIDTH), RW = $clog2(IMG_HEIGHT), SW = $clog2(KERNEL_SIZE-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle frame start; honoured only in IDLE
in_valid  in  1  source pixel valid
in_ready  out  1  controller accepts a pixel; accept = in_valid & in_ready
rb_en  out  1  row-buffer access (read-before-write at rb_addr); equals accept
rb_addr  out  CW  column address shared by all row buffers
rb_wr_sel  out  SW  index of the row buffer written on this access
steer_sel  out  SW  rotation index to steer stage, registered
win_valid  out  1  steer output holds a complete window column
win_col  out  CW  column of the window column flagged by win_valid
win_row  out  RW  row of the newest pixel in that window column
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (synchronous, at clk edge with rst=1): state=IDLE; col, row and wr_sel counters=0. All outputs 0: in_ready, rb_en, rb_addr, rb_wr_sel, steer_sel, win_valid, win_col, win_row, busy, frame_done. Pipeline valid flags are cleared. Reset mid-frame abandons the frame with no frame_done.
- FSM states: IDLE, FILL, ACTIVE, DONE.
  - IDLE: in_ready=0. start=1 -> FILL; counters zeroed.
  - FILL: rows 0..KERNEL_SIZE-2. in_ready=1. Accepts are written and no window is produced. Accepting the last pixel of row KERNEL_SIZE-2 -> ACTIVE.
  - ACTIVE: rows KERNEL_SIZE-1..IMG_HEIGHT-1. in_ready=1. Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
  - DONE: in_ready=0. Held for exactly 2 cycles to drain the pipeline, then -> IDLE. frame_done pulses on the cycle DONE exits.
- start outside IDLE is ignored. in_valid while in_ready=0 is ignored; no counter changes.
- Counters advance only on accept.
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - wr_sel increments on each row wrap, wrapping RB_COUNT-1 -> 0.
- Combinational outputs: rb_addr=col, rb_wr_sel=wr_sel, rb_en=accept.
- While row r is written, buffer wr_sel holds row r-RB_COUNT, the oldest row. The read-before-write at rb_addr returns it. The rotation select therefore equals wr_sel at the accept.
- Pipeline, for an accept at cycle t in ACTIVE:
  - t+1: steer_sel = wr_sel captured at t (row-buffer read data presented to steer).
  - t+2: win_valid=1, win_col=col at t, win_row=row at t.
- Accepts in FILL propagate with valid=0. steer_sel still updates but win_valid stays 0.
- Gaps on in_valid create matching bubbles: win_valid=0 two cycles later. steer_sel holds its last value.
- Window count per frame: (IMG_HEIGHT-KERNEL_SIZE+1)*IMG_WIDTH win_valid pulses.
- No output backpressure; downstream must consume win_valid cycles.

Test Plan:
All scenarios use KERNEL_SIZE=3, IMG_WIDTH=4, IMG_HEIGHT=6 (RB_COUNT=2, SW=1).
1. Reset mid-ACTIVE -> next cycle all outputs 0, state IDLE. A subsequent start plus 24 pixels completes normally with 16 win_valid pulses.
2. start, then 24 back-to-back valid pixels -> rb_wr_sel is 0 for pixels 0-3, 1 for 4-7, 0 for 8-11, 1 for 12-15, and so on. No win_valid during the first 8 accepts. The first win_valid occurs 2 cycles after accept #8 with win_col=0, win_row=2. Exactly 16 pulses total.
3. Same stream -> steer_sel=0 one cycle after accepts of row 2, =1 after row 3, =0 after row 4, =1 after row 5.
4. in_valid toggled 1,0,1,0 during ACTIVE -> rb_en follows the accepts; win_valid shows the same pattern delayed 2 cycles; col advances only on accepts.
5. Last pixel accepted at cycle t -> in_ready=0 from t+1; win_valid at t+2 with win_col=3, win_row=5; frame_done=1 at t+2 only; busy=0 at t+3.
6. start pulsed during FILL, and in_valid=1 in IDLE -> no state change, no rb_en, in_ready stays at its state-defined value.
